// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction memory loader.
//   loader_state_t      : loader FSM states
//   BYTES_PER_WORD      : stream bytes per instruction word
//   DEFAULT_INSTR_LEN   : default instruction word width
//   accepts_bytes()     : states in which the loader takes stream bytes
//   is_busy()           : states that count as a load in progress
package cpu_pkg;

    localparam int DEFAULT_INSTR_LEN = 32;
    localparam int BYTES_PER_WORD    = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DRAIN,
        DONE,
        ERROR
    } loader_state_t;

    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA);
    endfunction

    function automatic logic is_busy(input loader_state_t s);
        return accepts_bytes(s) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles a byte stream into big-endian words (first byte lands in the MSBs).
// Ports:
//   clk, nreset    : clock, async active-low reset
//   i_clear        : synchronous restart; drops any partial word
//   i_byte_valid   : a byte is accepted this cycle
//   i_byte_data    : the accepted byte
//   o_word_done    : combinational; this accepted byte completes a word
//   o_word_ready   : registered one-cycle pulse the cycle after a word completes
//   o_word_data    : assembly register; holds the full word while o_word_ready is high
module byte_word_packer
    import cpu_pkg::*;
#(
    parameter int INSTR_LEN = DEFAULT_INSTR_LEN
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 i_clear,
    input  logic                 i_byte_valid,
    input  logic [7:0]           i_byte_data,
    output logic                 o_word_done,
    output logic                 o_word_ready,
    output logic [INSTR_LEN-1:0] o_word_data
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]     r_byte_idx;
    logic [INSTR_LEN-1:0] r_shift;
    logic                 r_word_ready;
    logic                 w_last_byte;

    assign w_last_byte = i_byte_valid && (r_byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_clear) begin
                r_byte_idx <= '0;
                r_shift    <= '0;
            end else if (i_byte_valid) begin
                // The shift happens on the edge after a word_ready cycle at the
                // earliest, so the completed word is stable while it is written.
                r_shift      <= {r_shift[INSTR_LEN-9:0], i_byte_data};
                r_byte_idx   <= w_last_byte ? '0 : r_byte_idx + IDX_W'(1);
                r_word_ready <= w_last_byte;
            end
        end
    end

    assign o_word_done  = w_last_byte;
    assign o_word_ready = r_word_ready;
    assign o_word_data  = r_shift;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory writer: takes a 2-byte big-endian word count followed by
// the program bytes over a valid/ready byte stream and writes 32-bit words.
// Holds the CPU in reset until the whole program has been written.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LEN_HI | taking word count [15:8]
// LEN_LO | taking word count [7:0]; range check decides next state
// DATA   | streaming program bytes, one write per 4 bytes
// DRAIN  | final word write strobe
// DONE   | program loaded, CPU released; start reloads
// ERROR  | word count above capacity, CPU held; start retries
//
// Ports:
//   clk, nreset        : clock, async active-low reset
//   start              : load request, honoured in IDLE/DONE/ERROR only
//   in_valid, in_data  : byte stream in
//   in_ready           : byte accepted when in_valid & in_ready
//   wr_en/addr/data    : word write port, byte address word aligned
//   busy, done, error  : status (done and error sticky until next start)
//   cpu_hold           : high until a load completes
module instr_mem_loader
    import cpu_pkg::*;
#(
    parameter int INSTR_LEN     = DEFAULT_INSTR_LEN,
    parameter int MEM_ADDR_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [MEM_ADDR_SIZE-1:0] wr_addr,
    output logic [INSTR_LEN-1:0]     wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_hold
);

    localparam int WIDX_W = MEM_ADDR_SIZE - 2;
    // A 16-bit count can never exceed capacity once the memory holds 2^16 words.
    localparam logic [31:0] CAP_WORDS = (MEM_ADDR_SIZE >= 18) ? 32'h0001_0000
                                                              : (32'd1 << WIDX_W);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [7:0]        r_count_hi;
    logic [15:0]       r_count;
    logic [15:0]       r_words_rcvd;
    logic [WIDX_W-1:0] r_word_idx;

    logic                 w_accept;
    logic                 w_restart;
    logic [15:0]          w_count_full;
    logic                 w_count_over;
    logic                 w_byte_valid;
    logic                 w_word_done;
    logic                 w_word_ready;
    logic                 w_last_word;
    logic [INSTR_LEN-1:0] w_word_data;

    assign w_accept     = in_valid && accepts_bytes(r_state);
    assign w_restart    = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_count_full = {r_count_hi, in_data};
    assign w_count_over = ({16'd0, w_count_full} > CAP_WORDS);
    assign w_byte_valid = w_accept && (r_state == DATA);
    assign w_last_word  = w_word_done && (r_words_rcvd == r_count - 16'd1);

    byte_word_packer #(
        .INSTR_LEN (INSTR_LEN)
    ) u_packer (
        .clk          (clk),
        .nreset       (nreset),
        .i_clear      (w_restart),
        .i_byte_valid (w_byte_valid),
        .i_byte_data  (in_data),
        .o_word_done  (w_word_done),
        .o_word_ready (w_word_ready),
        .o_word_data  (w_word_data)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = LEN_HI;
            LEN_HI:  if (w_accept) w_next_state = LEN_LO;
            LEN_LO: begin
                if (w_accept) begin
                    if (w_count_full == 16'd0) begin
                        w_next_state = DONE;
                    end else if (w_count_over) begin
                        w_next_state = ERROR;
                    end else begin
                        w_next_state = DATA;
                    end
                end
            end
            DATA:    if (w_last_word) w_next_state = DRAIN;
            DRAIN:   w_next_state = DONE;
            DONE:    if (start) w_next_state = LEN_HI;
            ERROR:   if (start) w_next_state = LEN_HI;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_count_hi   <= '0;
            r_count      <= '0;
            r_words_rcvd <= '0;
            r_word_idx   <= '0;
        end else if (w_restart) begin
            r_words_rcvd <= '0;
            r_word_idx   <= '0;
        end else begin
            if ((r_state == LEN_HI) && w_accept) r_count_hi <= in_data;
            if ((r_state == LEN_LO) && w_accept) r_count    <= w_count_full;
            if (w_word_done)  r_words_rcvd <= r_words_rcvd + 16'd1;
            // Address advances after the write, so a full memory wraps only
            // once the final word has gone out.
            if (w_word_ready) r_word_idx   <= r_word_idx + WIDX_W'(1);
        end
    end

    assign in_ready = accepts_bytes(r_state);
    assign busy     = is_busy(r_state);
    assign done     = (r_state == DONE);
    assign error    = (r_state == ERROR);
    assign cpu_hold = (r_state != DONE);
    assign wr_en    = w_word_ready;
    assign wr_addr  = {r_word_idx, 2'b00};
    assign wr_data  = w_word_data;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. Two instances share the stimulus:
// dut_a with the default 16-bit address (capacity 16384 words) and dut_b with
// a 4-bit address (capacity 4 words). The stream is paced by dut_a's in_ready.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        a_in_ready, a_wr_en, a_busy, a_done, a_error, a_cpu_hold;
    logic [15:0] a_wr_addr;
    logic [31:0] a_wr_data;
    logic        b_in_ready, b_wr_en, b_busy, b_done, b_error, b_cpu_hold;
    logic [3:0]  b_wr_addr;
    logic [31:0] b_wr_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]  exp_bytes[$];
    logic [15:0] qa_addr[$];
    logic [31:0] qa_data[$];
    int          qa_cyc[$];
    logic [15:0] qb_addr[$];
    logic [31:0] qb_data[$];
    int          acc_cyc[$];
    logic        a_prev_wr = 1'b0;
    logic        b_prev_wr = 1'b0;
    int          done_cyc;
    logic        hold_at_done;
    logic        hold_before_done;

    instr_mem_loader dut_a (
        .clk(clk), .nreset(nreset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .error(a_error), .cpu_hold(a_cpu_hold)
    );

    instr_mem_loader #(.MEM_ADDR_SIZE(4)) dut_b (
        .clk(clk), .nreset(nreset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .error(b_error), .cpu_hold(b_cpu_hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write capture; a word needs four byte cycles, so strobes never touch.
    always @(negedge clk) begin
        if (a_wr_en) begin
            n_checks++;
            if (a_prev_wr) $display("FAIL a_wr_en_back_to_back cyc=%0d got=1 want=0", cyc);
            else n_pass++;
            qa_addr.push_back(a_wr_addr);
            qa_data.push_back(a_wr_data);
            qa_cyc.push_back(cyc);
        end
        if (b_wr_en) begin
            n_checks++;
            if (b_prev_wr) $display("FAIL b_wr_en_back_to_back cyc=%0d got=1 want=0", cyc);
            else n_pass++;
            qb_addr.push_back({12'd0, b_wr_addr});
            qb_data.push_back(b_wr_data);
        end
        a_prev_wr = a_wr_en;
        b_prev_wr = b_wr_en;
    end

    // Reference: word i is bytes 4i..4i+3 of the program, first byte in the MSBs.
    function automatic logic [31:0] model_word(input int i);
        return {exp_bytes[4*i], exp_bytes[4*i+1], exp_bytes[4*i+2], exp_bytes[4*i+3]};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = a_in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL byte_accept_timeout byte=%02h got=not_accepted want=accepted", b);
        else begin
            n_pass++;
            acc_cyc.push_back(cyc);
        end
    endtask

    task automatic run_load(input int count, input int gap_max, input bit preset, input int mid_start);
        if (!preset) begin
            exp_bytes.delete();
            for (int i = 0; i < count * 4; i++) exp_bytes.push_back(8'($urandom));
        end
        qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
        qb_addr.delete(); qb_data.delete(); acc_cyc.delete();
        pulse_start();
        send_byte(8'(count >> 8), (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        send_byte(8'(count),      (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        for (int j = 0; j < count * 4; j++) begin
            if (j == mid_start) pulse_start();
            send_byte(exp_bytes[j], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        end
        done_cyc = -1;
        hold_before_done = 1'b1;
        hold_at_done = 1'b1;
        for (int k = 0; k < 40 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (a_done) begin
                done_cyc = cyc;
                hold_at_done = a_cpu_hold;
            end else begin
                hold_before_done = a_cpu_hold;
            end
        end
        n_checks++;
        if (done_cyc < 0) $display("FAIL done_timeout count=%0d got=done_low want=done_high", count);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_in_ready, a_wr_en, a_busy, a_done, a_error, a_cpu_hold} !== 6'b000001)
            $display("FAIL reset_a_flags got=%06b want=000001",
                     {a_in_ready, a_wr_en, a_busy, a_done, a_error, a_cpu_hold});
        else n_pass++;
        n_checks++;
        if (a_wr_addr !== 16'h0 || a_wr_data !== 32'h0)
            $display("FAIL reset_a_wr got=%h/%h want=0000/00000000", a_wr_addr, a_wr_data);
        else n_pass++;
        n_checks++;
        if ({b_in_ready, b_wr_en, b_busy, b_done, b_error, b_cpu_hold} !== 6'b000001)
            $display("FAIL reset_b_flags got=%06b want=000001",
                     {b_in_ready, b_wr_en, b_busy, b_done, b_error, b_cpu_hold});
        else n_pass++;
        @(posedge clk); #1;
        nreset = 1'b1;
        // Stream bytes offered while idle must be ignored.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL idle_ignores_valid got=ready%b_busy%b want=ready0_busy0", a_in_ready, a_busy);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (qa_addr.size() != 0) $display("FAIL idle_no_write got=%0d want=0", qa_addr.size());
        else n_pass++;
    endtask

    task automatic test_basic();
        exp_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        run_load(2, 0, 1'b1, -1);
        n_checks++;
        if (qa_addr.size() != 2) $display("FAIL basic_write_count got=%0d want=2", qa_addr.size());
        else n_pass++;
        n_checks++;
        if (qa_addr[0] !== 16'h0000 || qa_data[0] !== 32'hDEADBEEF)
            $display("FAIL basic_word0 got=%h:%h want=0000:deadbeef", qa_addr[0], qa_data[0]);
        else n_pass++;
        n_checks++;
        if (qa_addr[1] !== 16'h0004 || qa_data[1] !== 32'h01234567)
            $display("FAIL basic_word1 got=%h:%h want=0004:01234567", qa_addr[1], qa_data[1]);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (qa_cyc[i] != acc_cyc[2 + 4*i + 3])
                $display("FAIL basic_latency word=%0d got=%0d want=%0d", i, qa_cyc[i], acc_cyc[2 + 4*i + 3]);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc != qa_cyc[1] + 1)
            $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, qa_cyc[1] + 1);
        else n_pass++;
        n_checks++;
        if (hold_before_done !== 1'b1 || hold_at_done !== 1'b0)
            $display("FAIL basic_cpu_hold got=before%b_at%b want=before1_at0", hold_before_done, hold_at_done);
        else n_pass++;
        n_checks++;
        if (qb_addr.size() != 2 || qb_data[1] !== 32'h01234567)
            $display("FAIL basic_b_writes got=%0d want=2", qb_addr.size());
        else n_pass++;
    endtask

    task automatic test_zero();
        qa_addr.delete(); qb_addr.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_checks++;
        if (a_done !== 1'b1 || a_error !== 1'b0 || b_done !== 1'b1)
            $display("FAIL zero_done_edge got=a%b%b_b%b want=a10_b1", a_done, a_error, b_done);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (qa_addr.size() != 0 || qb_addr.size() != 0)
            $display("FAIL zero_no_write got=%0d/%0d want=0/0", qa_addr.size(), qb_addr.size());
        else n_pass++;
    endtask

    task automatic test_error();
        run_load(5, 0, 1'b0, -1);
        n_checks++;
        if ({b_error, b_in_ready, b_cpu_hold, b_done, b_busy} !== 5'b10100)
            $display("FAIL error_b_flags got=%05b want=10100", {b_error, b_in_ready, b_cpu_hold, b_done, b_busy});
        else n_pass++;
        n_checks++;
        if (qb_addr.size() != 0) $display("FAIL error_b_no_write got=%0d want=0", qb_addr.size());
        else n_pass++;
        n_checks++;
        if (qa_addr.size() != 5) $display("FAIL error_a_write_count got=%0d want=5", qa_addr.size());
        else n_pass++;
        for (int i = 0; i < qa_addr.size() && i < 5; i++) begin
            n_checks++;
            if (qa_addr[i] !== 16'(4*i) || qa_data[i] !== model_word(i))
                $display("FAIL error_a_word%0d got=%h:%h want=%h:%h", i, qa_addr[i], qa_data[i], 16'(4*i), model_word(i));
            else n_pass++;
        end
    endtask

    task automatic test_capacity();
        run_load(4, 0, 1'b0, -1);
        n_checks++;
        if (b_done !== 1'b1 || b_error !== 1'b0)
            $display("FAIL cap_b_status got=done%b_err%b want=done1_err0", b_done, b_error);
        else n_pass++;
        n_checks++;
        if (qb_addr.size() != 4) $display("FAIL cap_b_write_count got=%0d want=4", qb_addr.size());
        else n_pass++;
        for (int i = 0; i < qb_addr.size() && i < 4; i++) begin
            n_checks++;
            if (qb_addr[i] !== 16'(4*i) || qb_data[i] !== model_word(i))
                $display("FAIL cap_b_word%0d got=%h:%h want=%h:%h", i, qb_addr[i], qb_data[i], 16'(4*i), model_word(i));
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        for (int it = 0; it < 6; it++) begin
            int count;
            count = int'($urandom_range(6, 1));
            run_load(count, 3, 1'b0, -1);
            n_checks++;
            if (qa_addr.size() != count)
                $display("FAIL gaps_a_count it=%0d got=%0d want=%0d", it, qa_addr.size(), count);
            else n_pass++;
            for (int i = 0; i < qa_addr.size() && i < count; i++) begin
                n_checks++;
                if (qa_addr[i] !== 16'(4*i) || qa_data[i] !== model_word(i))
                    $display("FAIL gaps_a_word it=%0d w=%0d got=%h:%h want=%h:%h",
                             it, i, qa_addr[i], qa_data[i], 16'(4*i), model_word(i));
                else n_pass++;
                n_checks++;
                if (qa_cyc[i] != acc_cyc[2 + 4*i + 3])
                    $display("FAIL gaps_latency it=%0d w=%0d got=%0d want=%0d", it, i, qa_cyc[i], acc_cyc[2 + 4*i + 3]);
                else n_pass++;
            end
            n_checks++;
            if (count > 4) begin
                if (b_error !== 1'b1 || qb_addr.size() != 0)
                    $display("FAIL gaps_b_error it=%0d got=err%b_w%0d want=err1_w0", it, b_error, qb_addr.size());
                else n_pass++;
            end else begin
                if (b_done !== 1'b1 || qb_addr.size() != count || qb_data[count-1] !== model_word(count-1))
                    $display("FAIL gaps_b_done it=%0d got=done%b_w%0d want=done1_w%0d", it, b_done, qb_addr.size(), count);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int j = 0; j < 6; j++) send_byte(8'($urandom), 0);
        nreset = 1'b0;
        #1;
        n_checks++;
        if ({a_in_ready, a_wr_en, a_busy, a_done, a_error, a_cpu_hold} !== 6'b000001 ||
            a_wr_addr !== 16'h0 || a_wr_data !== 32'h0)
            $display("FAIL midreset_a got=%06b_%h_%h want=000001_0000_00000000",
                     {a_in_ready, a_wr_en, a_busy, a_done, a_error, a_cpu_hold}, a_wr_addr, a_wr_data);
        else n_pass++;
        n_checks++;
        if ({b_in_ready, b_busy, b_cpu_hold} !== 3'b001 || b_wr_data !== 32'h0)
            $display("FAIL midreset_b got=%03b_%h want=001_00000000", {b_in_ready, b_busy, b_cpu_hold}, b_wr_data);
        else n_pass++;
        #2;
        nreset = 1'b1;
        run_load(3, 0, 1'b0, -1);
        n_checks++;
        if (qa_addr.size() != 3) $display("FAIL midreset_reload_count got=%0d want=3", qa_addr.size());
        else n_pass++;
        for (int i = 0; i < qa_addr.size() && i < 3; i++) begin
            n_checks++;
            if (qa_addr[i] !== 16'(4*i) || qa_data[i] !== model_word(i))
                $display("FAIL midreset_reload w=%0d got=%h:%h want=%h:%h", i, qa_addr[i], qa_data[i], 16'(4*i), model_word(i));
            else n_pass++;
        end
    endtask

    task automatic test_start_in_data();
        run_load(3, 1, 1'b0, 5);
        n_checks++;
        if (qa_addr.size() != 3) $display("FAIL start_in_data_count got=%0d want=3", qa_addr.size());
        else n_pass++;
        for (int i = 0; i < qa_addr.size() && i < 3; i++) begin
            n_checks++;
            if (qa_addr[i] !== 16'(4*i) || qa_data[i] !== model_word(i))
                $display("FAIL start_in_data w=%0d got=%h:%h want=%h:%h", i, qa_addr[i], qa_data[i], 16'(4*i), model_word(i));
            else n_pass++;
        end
    endtask

    task automatic test_start_in_done();
        n_checks++;
        if (a_done !== 1'b1 || a_cpu_hold !== 1'b0)
            $display("FAIL done_before_start got=done%b_hold%b want=done1_hold0", a_done, a_cpu_hold);
        else n_pass++;
        pulse_start();
        @(negedge clk);
        n_checks++;
        if ({a_done, a_cpu_hold, a_busy, a_in_ready} !== 4'b0111)
            $display("FAIL start_in_done got=%04b want=0111", {a_done, a_cpu_hold, a_busy, a_in_ready});
        else n_pass++;
        @(posedge clk); #1;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_checks++;
        if (a_done !== 1'b1) $display("FAIL reload_zero_done got=%b want=1", a_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_error();
        test_capacity();
        test_gaps();
        test_reset_mid();
        test_start_in_data();
        test_start_in_done();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory. Fetch reads 32-bit big-endian words, byte-addressed by pc; this block fills that memory.
- Accepts a byte stream over a valid/ready handshake: a 2-byte big-endian word count, then the program bytes.
- Assembles the bytes into 32-bit big-endian words and issues one word write per word.
- Holds the CPU in reset until the program has been written.

Parameters:
- INSTR_LEN, 32, word width written to memory; fixed at 32, 4 bytes per word.
- MEM_ADDR_SIZE, 16, byte-address width of instruction memory; capacity is 2^(MEM_ADDR_SIZE-2) words.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERROR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle memory write strobe.
- wr_addr  out  MEM_ADDR_SIZE  byte address of the word; always a multiple of 4.
- wr_data  out  INSTR_LEN  word; [31:24] goes to wr_addr, [7:0] goes to wr_addr+3.
- busy  out  1  load in progress.
- done  out  1  sticky; load completed.
- error  out  1  sticky; word count exceeded memory capacity.
- cpu_hold  out  1  held high from reset until done; CPU core nreset is gated by it.

Behaviour:
- Reset (async, nreset=0):
  - State goes to IDLE; counters and the byte assembly register clear; any partial word is discarded.
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1.
- Handshake: a byte transfers on a posedge with in_valid & in_ready. in_ready is a registered function of state: 1 in LEN_HI, LEN_LO and DATA, 0 elsewhere.
- States:
  - IDLE: start -> LEN_HI; clear done, error, word counter and byte index.
  - LEN_HI: accepted byte -> count[15:8]; go to LEN_LO.
  - LEN_LO: accepted byte -> count[7:0], then:
    - count==0 -> DONE.
    - count > 2^(MEM_ADDR_SIZE-2) -> ERROR.
    - otherwise -> DATA.
  - DATA: byte index 0..3 shifts bytes into the assembly register, MSB first.
    - On the 4th accepted byte, the next cycle has wr_en=1, wr_data = the assembled word, wr_addr = word_index*4. word_index then increments.
    - Latency from accepting the 4th byte to the wr_en cycle is 1.
    - Bytes of the next word may be accepted in the same cycle as wr_en, so back-to-back streaming runs at 1 byte/cycle.
    - After the last byte of word count-1 is accepted -> DRAIN.
  - DRAIN: the final wr_en is asserted this cycle; then -> DONE.
  - DONE: done=1, busy=0, cpu_hold=0. done therefore rises the cycle after the final wr_en. start -> LEN_HI and reload (clears done; cpu_hold=1).
  - ERROR: error=1, busy=0, cpu_hold=1, no writes. start -> LEN_HI.
- busy=1 in LEN_HI, LEN_LO, DATA and DRAIN.
- start while busy is ignored.
- in_valid outside the handshake states is ignored (in_ready=0).
- Widths and limits:
  - word_index is MEM_ADDR_SIZE-2 bits.
  - Count equal to capacity is legal and fills memory exactly; wr_addr never wraps.
  - count is 16 bits. For MEM_ADDR_SIZE>18 no error is possible.
- Stalls: in_valid low mid-word holds byte index and assembly register indefinitely.
- wr_en is never asserted in two consecutive cycles, because a word needs at least 4 byte cycles.

Decomposition:
- Shared package (cpu_pkg): loader state enum (IDLE, LEN_HI, LEN_LO, DATA, DRAIN, DONE, ERROR), BYTES_PER_WORD=4, INSTR_LEN default.
- One natural sub-module: byte_word_packer. It holds the byte index, the shift register and the word_ready pulse. The FSM, counters and address generation stay in instr_mem_loader.

Test Plan:
- Reset then start; stream 00 02 DE AD BE EF 01 23 45 67 at 1 byte/cycle -> wr_en with addr 0x0000 data 0xDEADBEEF, then addr 0x0004 data 0x01234567; done=1 one cycle after the second wr_en; cpu_hold falls with done.
- Stream 00 00 -> no wr_en; DONE entered on the edge accepting the second length byte; done=1, error=0.
- MEM_ADDR_SIZE=4, stream 00 05 -> ERROR; error=1, in_ready=0, no wr_en, cpu_hold stays 1. Then start with 00 04 plus 16 bytes -> last write at addr 0xC; done=1.
- Random in_valid gaps inside words (e.g. 1 byte every 3 cycles) -> identical wr_addr/wr_data sequence to gap-free; wr_en only after each 4th byte.
- Drop nreset after 2 data bytes of word 1 -> all outputs at reset values immediately. Restart and a full reload writes the correct words from addr 0, with no stale bytes.
- Pulse start during DATA -> ignored, transfer continues unchanged. start in DONE -> done clears and cpu_hold=1 on the next cycle.
